// File: rtl/mult_sequencer_if.sv
// Control/status bundle between mult_sequencer and the shift-and-add datapath.
interface mult_sequencer_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 start;
  logic                 multiplier_lsb;
  logic                 load;
  logic                 add_en;
  logic                 shift;
  logic [CNT_WIDTH-1:0] count;
  logic                 busy;
  logic                 ready;
  logic                 done;

  modport master (
    input  start, multiplier_lsb,
    output load, add_en, shift, count, busy, ready, done
  );

  modport slave (
    output start, multiplier_lsb,
    input  load, add_en, shift, count, busy, ready, done
  );
endinterface

// File: rtl/mult_sequencer.sv
// Sequencer for the shift-and-add multiplier: load strobe, WORD_LENGTH shift/add
// iterations gated by the multiplier LSB, then a one-cycle done pulse.
module mult_sequencer #(
  parameter int WORD_LENGTH = 8,
  parameter int CNT_WIDTH   = $clog2(WORD_LENGTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  mult_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(WORD_LENGTH);

  state_t               state, state_nx;
  logic                 start_d;
  logic                 start_rise;
  logic [CNT_WIDTH-1:0] count, count_nx;

  // start_d tracks start in every state, so an edge seen while busy is lost.
  assign start_rise = bus.start & ~start_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_d <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nx;
      start_d <= bus.start;
      count   <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nx = LOAD;
          count_nx = '0;
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        if (count == LAST_ITER) begin
          state_nx = DONE;
          count_nx = FULL_CNT;
        end else begin
          count_nx = count + CNT_WIDTH'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.load   = (state == LOAD);
  assign bus.shift  = (state == RUN);
  assign bus.add_en = (state == RUN) & bus.multiplier_lsb;
  assign bus.busy   = (state == LOAD) || (state == RUN);
  assign bus.ready  = (state == IDLE);
  assign bus.done   = (state == DONE);
  assign bus.count  = count;

endmodule
